sd_spi_master: RTL and testbench
================================

SD_SPI_MASTER -- requirements
Module: sd_spi_master

Interface
REQ-001 Parameter DIV_RESET, default 59, reset value of DIV register (SCLK half-period = DIV+1 clocks; 59 -> 400 kHz at 48 MHz).
REQ-002 MHZ48  in  1  master clock; all state on rising edge.
REQ-003 RES  in  1  reset, asynchronous, active-high.
REQ-004 CS  in  1  register access strobe, one MHZ48 cycle per CPU bus access.
REQ-005 RW  in  1  1 = read, 0 = write; qualified by CS.
REQ-006 A  in  2  register select.
REQ-007 DIN  in  8  write data.
REQ-008 DOUT  out  8  read data, combinational from A, valid regardless of CS.
REQ-009 SCLK  out  1  SPI clock, mode 0.
REQ-010 MOSI  out  1  SPI data out.
REQ-011 MISO  in  1  SPI data in.
REQ-012 nSD0, nSD1  out  1 each  card selects, active low.
REQ-013 IRQ  out  1  completion interrupt; present only with SD_SPI_IRQ_EN.

Function
REQ-014 Register map: A=0 DATA; A=1 CTRL/STATUS; A=2 DIV; A=3 reads 0x00, writes ignored.
REQ-015 DATA write: loads TX shift register, starts transfer; DATA read: returns last RX byte and clears DONE.
REQ-016 STATUS read bits: [0]nSD0 [1]nSD1 [4]BUSY [5]DONE [6]OVR [7]IEN; others 0.
REQ-017 CTRL write: [0]->nSD0, [1]->nSD1, [7]->IEN, [6]=1 clears OVR; other bits ignored.
REQ-018 FSM states IDLE, LOW, HIGH; 8-bit half-period counter reloads DIV on each phase entry; 3-bit bit counter.
REQ-019 IDLE: SCLK=0, MOSI=1, BUSY=0; DATA write at cycle t -> LOW at t+1, BUSY=1, MOSI=TX[7].
REQ-020 LOW for DIV+1 cycles, then HIGH: SCLK=1, MISO shifted into RX LSB at that transition.
REQ-021 HIGH for DIV+1 cycles, then: bit counter <7 -> LOW, next TX bit on MOSI; bit counter =7 -> IDLE, SCLK=0, MOSI=1, DONE=1, RX byte visible.
REQ-022 BUSY asserted exactly 16*(DIV+1) cycles per byte; bytes MSB first.
REQ-023 Any DATA, CTRL or DIV write while BUSY: ignored, sets OVR (sticky); reads while BUSY allowed, DATA read returns previous RX byte.
REQ-024 DONE set and DATA read in same cycle: DONE remains 1 (set wins).
REQ-025 OVR set and CTRL clear in same cycle: OVR remains 1.
REQ-026 DIV=0 legal: one-cycle half-periods, 16-cycle byte.

Reset
REQ-027 RES asserted, any state: FSM IDLE, SCLK=0, MOSI=1, nSD0=nSD1=1, TX=RX=0x00, DONE=OVR=IEN=0, DIV=DIV_RESET, IRQ=0, immediately (asynchronous).
REQ-028 Reset mid-transfer aborts byte; DONE not set after release.

Configuration
REQ-029 SD_SPI_IRQ_EN defined: IRQ port exists, IRQ = DONE & IEN, registered-free combinational.
REQ-030 SD_SPI_IRQ_EN undefined: no IRQ port, IEN not implemented, STATUS[7] reads 0, CTRL[7] write ignored.

Structure
REQ-031 Package sd_spi_pkg holds register address constants, STATUS/CTRL bit indices, FSM state enum, DIV_RESET default.
REQ-032 Sub-module sd_spi_clkdiv: half-period down-counter, inputs load/DIV, output one-cycle tick.

Verification
REQ-033 Reset: all outputs per REQ-027; DIV read = 0x3B.
REQ-034 DIV=0, CTRL=0x02, DATA=0xA5, MISO loopback from MOSI: BUSY 16 cycles, SCLK 8 pulses, MOSI 1,0,1,0,0,1,0,1, DONE=1, DATA read = 0xA5, DONE then 0.
REQ-035 DIV=3, DATA=0x00, MISO tied 1: BUSY 64 cycles, each SCLK phase 4 cycles, RX = 0xFF.
REQ-036 DATA write 0x12 mid-transfer of 0x55: shifted byte stays 0x55, OVR=1; CTRL write 0x40 after completion clears OVR.
REQ-037 RES pulse at bit 4 of a transfer: SCLK=0, MOSI=1, nSD0=nSD1=1 same cycle, DONE=0 after release.
REQ-038 With SD_SPI_IRQ_EN, IEN=1: IRQ rises with DONE at end of byte, falls after DATA read; IEN=0: IRQ stays 0.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// ============================================================================
// Module   : sd_spi_pkg
// Brief    : Shared constants, register map and FSM encoding for the SD SPI
//            master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_spi_pkg;

    localparam logic [7:0] DIV_RESET_DEFAULT = 8'd59;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_DIV  = 2'd2;
    localparam logic [1:0] ADDR_NONE = 2'd3;

    localparam int STAT_NSD0 = 0;
    localparam int STAT_NSD1 = 1;
    localparam int STAT_BUSY = 4;
    localparam int STAT_DONE = 5;
    localparam int STAT_OVR  = 6;
    localparam int STAT_IEN  = 7;

    localparam int CTRL_NSD0    = 0;
    localparam int CTRL_NSD1    = 1;
    localparam int CTRL_OVR_CLR = 6;
    localparam int CTRL_IEN     = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/sd_spi_if.sv
// ============================================================================
// Module   : sd_spi_if
// Brief    : CPU register bus and SPI pins of the SD SPI master.
//            IRQ exists only when SD_SPI_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sd_spi_if;
    logic       CS;
    logic       RW;
    logic [1:0] A;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;
    logic       nSD0;
    logic       nSD1;
`ifdef SD_SPI_IRQ_EN
    logic       IRQ;

    modport master (input CS, RW, A, DIN, MISO, output DOUT, SCLK, MOSI, nSD0, nSD1, IRQ);
    modport slave  (output CS, RW, A, DIN, MISO, input DOUT, SCLK, MOSI, nSD0, nSD1, IRQ);
`else
    modport master (input CS, RW, A, DIN, MISO, output DOUT, SCLK, MOSI, nSD0, nSD1);
    modport slave  (output CS, RW, A, DIN, MISO, input DOUT, SCLK, MOSI, nSD0, nSD1);
`endif
endinterface

`default_nettype wire

// File: rtl/sd_spi_clkdiv.sv
// ============================================================================
// Module   : sd_spi_clkdiv
// Brief    : Half-period down-counter; o_tick marks the last cycle of a phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_spi_clkdiv (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_load,
    input  wire logic [7:0] i_div,
    output logic            o_tick
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_div;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == 8'd0);

endmodule

`default_nettype wire

// File: rtl/sd_spi_master.sv
// ============================================================================
// Module   : sd_spi_master
// Brief    : Byte-wide SPI mode-0 master for SD cards with CPU register port.
//            Define SD_SPI_IRQ_EN to add the IEN bit and the IRQ output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter logic [7:0] DIV_RESET = DIV_RESET_DEFAULT
) (
    input  wire logic  MHZ48,
    input  wire logic  RES,
    sd_spi_if.master   bus
);

    spi_state_e state_q, state_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] div_q, div_d;
    logic       nsd0_q, nsd0_d;
    logic       nsd1_q, nsd1_d;
    logic       done_q, done_d;
    logic       ovr_q, ovr_d;

    logic       w_tick;
    logic       w_load;
    logic       w_busy;
    logic       w_wr;
    logic       w_rd_data;
    logic       w_done_set;
    logic       w_ien;
    logic [7:0] w_status;

    sd_spi_clkdiv u_clkdiv (
        .clk    (MHZ48),
        .rst    (RES),
        .i_load (w_load),
        .i_div  (div_q),
        .o_tick (w_tick)
    );

    assign w_busy    = (state_q != ST_IDLE);
    assign w_wr      = bus.CS & ~bus.RW;
    assign w_rd_data = bus.CS & bus.RW & (bus.A == ADDR_DATA);

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        bit_d      = bit_q;
        div_d      = div_q;
        nsd0_d     = nsd0_q;
        nsd1_d     = nsd1_q;
        done_d     = done_q;
        ovr_d      = ovr_q;
        w_load     = 1'b0;
        w_done_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_wr && (bus.A == ADDR_DATA)) begin
                    state_d = ST_LOW;
                    bit_d   = 3'd0;
                    w_load  = 1'b1;
                end
            end
            ST_LOW: begin
                if (w_tick) begin
                    state_d    = ST_HIGH;
                    w_load     = 1'b1;
                    rx_shift_d = {rx_shift_q[6:0], bus.MISO};
                end
            end
            ST_HIGH: begin
                if (w_tick) begin
                    w_load = 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d    = ST_IDLE;
                        rx_data_d  = rx_shift_q;
                        w_done_set = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        bit_d   = bit_q + 3'd1;
                        tx_d    = {tx_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Writes are only honoured while idle; any attempt during a byte is an overrun.
        if (w_wr && (bus.A != ADDR_NONE) && !w_busy) begin
            case (bus.A)
                ADDR_DATA: tx_d = bus.DIN;
                ADDR_CTRL: begin
                    nsd0_d = bus.DIN[CTRL_NSD0];
                    nsd1_d = bus.DIN[CTRL_NSD1];
                    if (bus.DIN[CTRL_OVR_CLR]) begin
                        ovr_d = 1'b0;
                    end
                end
                ADDR_DIV:  div_d = bus.DIN;
                default:   ;
            endcase
        end
        if (w_wr && (bus.A != ADDR_NONE) && w_busy) begin
            ovr_d = 1'b1;
        end

        if (w_rd_data) begin
            done_d = 1'b0;
        end
        if (w_done_set) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            state_q    <= ST_IDLE;
            tx_q       <= 8'h00;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            bit_q      <= 3'd0;
            div_q      <= DIV_RESET;
            nsd0_q     <= 1'b1;
            nsd1_q     <= 1'b1;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            bit_q      <= bit_d;
            div_q      <= div_d;
            nsd0_q     <= nsd0_d;
            nsd1_q     <= nsd1_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
        end
    end

`ifdef SD_SPI_IRQ_EN
    logic ien_q, ien_d;

    always_comb begin
        ien_d = ien_q;
        if (w_wr && (bus.A == ADDR_CTRL) && !w_busy) begin
            ien_d = bus.DIN[CTRL_IEN];
        end
    end

    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            ien_q <= 1'b0;
        end else begin
            ien_q <= ien_d;
        end
    end

    assign w_ien   = ien_q;
    assign bus.IRQ = done_q & ien_q;
`else
    assign w_ien = 1'b0;
`endif

    always_comb begin
        w_status            = 8'h00;
        w_status[STAT_NSD0] = nsd0_q;
        w_status[STAT_NSD1] = nsd1_q;
        w_status[STAT_BUSY] = w_busy;
        w_status[STAT_DONE] = done_q;
        w_status[STAT_OVR]  = ovr_q;
        w_status[STAT_IEN]  = w_ien;
    end

    always_comb begin
        bus.DOUT = 8'h00;
        case (bus.A)
            ADDR_DATA: bus.DOUT = rx_data_q;
            ADDR_CTRL: bus.DOUT = w_status;
            ADDR_DIV:  bus.DOUT = div_q;
            ADDR_NONE: bus.DOUT = 8'h00;
            default:   bus.DOUT = 8'h00;
        endcase
    end

    // Mode 0: clock idles low and MOSI idles high between bytes.
    assign bus.SCLK = (state_q == ST_HIGH);
    assign bus.MOSI = (state_q == ST_IDLE) ? 1'b1 : tx_q[7];
    assign bus.nSD0 = nsd0_q;
    assign bus.nSD1 = nsd1_q;

endmodule

`default_nettype wire

// File: tb/tb_sd_spi_master.sv
// ============================================================================
// Module   : tb_sd_spi_master
// Brief    : Self-checking bench for sd_spi_master (IRQ checks with SD_SPI_IRQ_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_spi_master;

`ifdef SD_SPI_IRQ_EN
    localparam logic [7:0] IEN_BIT = 8'h80;
`else
    localparam logic [7:0] IEN_BIT = 8'h00;
`endif

    logic clk = 1'b0;
    logic res = 1'b1;
    logic loop_en = 1'b1;
    logic miso_tie = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_spi_if bus ();
    assign bus.MISO = loop_en ? bus.MOSI : miso_tie;

    sd_spi_master #(.DIV_RESET(8'd59)) dut (
        .MHZ48 (clk),
        .RES   (res),
        .bus   (bus)
    );

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int         m_k = -1;       // cycles since start of current byte, -1 when idle
    int         m_hp = 1;       // half-period length in clocks for the current byte
    logic [7:0] m_div, m_tx, m_rx, m_acc;
    logic       m_nsd0, m_nsd1, m_done, m_ovr, m_ien;

    logic       s_cs, s_rw, s_miso;
    logic [1:0] s_a;
    logic [7:0] s_din;

    always @(posedge clk) begin
        s_cs   <= bus.CS;
        s_rw   <= bus.RW;
        s_a    <= bus.A;
        s_din  <= bus.DIN;
        s_miso <= bus.MISO;
    end

    task automatic m_reset();
        m_k = -1; m_hp = 1;
        m_div = 8'd59; m_tx = 8'h00; m_rx = 8'h00; m_acc = 8'h00;
        m_nsd0 = 1'b1; m_nsd1 = 1'b1; m_done = 1'b0; m_ovr = 1'b0; m_ien = 1'b0;
    endtask

    task automatic m_step();
        bit busy0 = (m_k >= 0);
        bit fin   = busy0 && (m_k == 16 * m_hp - 1);
        if (busy0 && ((m_k / m_hp) % 2 == 0) && (m_k % m_hp == m_hp - 1))
            m_acc = {m_acc[6:0], s_miso};
        if (busy0) m_k = fin ? -1 : m_k + 1;
        if (s_cs && !s_rw && s_a != 2'd3) begin
            if (busy0) m_ovr = 1'b1;
            else begin
                case (s_a)
                    2'd0: begin m_tx = s_din; m_k = 0; m_hp = int'(m_div) + 1; end
                    2'd1: begin
                        m_nsd0 = s_din[0];
                        m_nsd1 = s_din[1];
                        if (IEN_BIT != 8'h00) m_ien = s_din[7];
                        if (s_din[6]) m_ovr = 1'b0;
                    end
                    2'd2: m_div = s_din;
                    default: ;
                endcase
            end
        end
        if (s_cs && s_rw && s_a == 2'd0) m_done = 1'b0;
        if (fin) begin m_done = 1'b1; m_rx = m_acc; end
    endtask

    int         c_ph;
    logic       c_busy, c_sclk, c_mosi;
    logic [7:0] c_stat, c_dout;

    always @(negedge clk) begin
        if (res) m_reset();
        else m_step();
        c_busy = (m_k >= 0);
        c_ph   = c_busy ? m_k / m_hp : 0;
        c_sclk = c_busy ? (c_ph % 2 == 1) : 1'b0;
        c_mosi = c_busy ? m_tx[7 - c_ph / 2] : 1'b1;
        c_stat = {m_ien, m_ovr, m_done, c_busy, 2'b00, m_nsd1, m_nsd0};
        case (bus.A)
            2'd0: c_dout = m_rx;
            2'd1: c_dout = c_stat;
            2'd2: c_dout = m_div;
            default: c_dout = 8'h00;
        endcase
        check("cyc_sclk", int'(bus.SCLK), int'(c_sclk));
        check("cyc_mosi", int'(bus.MOSI), int'(c_mosi));
        check("cyc_nsd0", int'(bus.nSD0), int'(m_nsd0));
        check("cyc_nsd1", int'(bus.nSD1), int'(m_nsd1));
        check("cyc_dout", int'(bus.DOUT), int'(c_dout));
`ifdef SD_SPI_IRQ_EN
        check("cyc_irq", int'(bus.IRQ), int'(m_done & m_ien));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); #1;
        bus.CS = 1'b1; bus.RW = 1'b0; bus.A = a; bus.DIN = d;
        @(negedge clk); #1;
        bus.CS = 1'b0; bus.RW = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
        bus.CS = 1'b0; bus.RW = 1'b1; bus.A = a;
        #1;
        d = bus.DOUT;
    endtask

    task automatic read_data_strobe(output logic [7:0] d);
        @(negedge clk); #1;
        bus.CS = 1'b1; bus.RW = 1'b1; bus.A = 2'd0;
        #1;
        d = bus.DOUT;
        @(negedge clk); #1;
        bus.CS = 1'b0;
    endtask

    // Follows a byte from just after its DATA write until BUSY drops.
    task automatic wait_byte(input int inj_at, input logic [7:0] inj_d,
                             output int busy_cnt, output int rises, output logic [7:0] seq);
        logic prev;
        bit   ended;
        prev = 1'b0; ended = 1'b0; busy_cnt = 0; rises = 0; seq = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            bus.CS = 1'b0; bus.RW = 1'b1; bus.A = 2'd1;
            #1;
            if (!bus.DOUT[4]) begin
                ended = 1'b1;
                break;
            end
            busy_cnt++;
            if (bus.SCLK && !prev) begin
                rises++;
                seq = {seq[6:0], bus.MOSI};
            end
            prev = bus.SCLK;
            if (i == inj_at) begin
                bus.CS = 1'b1; bus.RW = 1'b0; bus.A = 2'd0; bus.DIN = inj_d;
            end
            @(negedge clk); #1;
        end
        if (!ended) check("byte_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [7:0] seq;
        int         bc, rises;

        bus.CS = 1'b0; bus.RW = 1'b1; bus.A = 2'd0; bus.DIN = 8'h00;
        res = 1'b1;
        repeat (3) @(negedge clk);
        #1 res = 1'b0;

        // Reset state
        check("rst_sclk", int'(bus.SCLK), 0);
        check("rst_mosi", int'(bus.MOSI), 1);
        check("rst_nsd0", int'(bus.nSD0), 1);
        check("rst_nsd1", int'(bus.nSD1), 1);
        read_reg(2'd2, d); check("rst_div", int'(d), 8'h3B);
        read_reg(2'd1, d); check("rst_status", int'(d), 8'h03);
        read_reg(2'd0, d); check("rst_data", int'(d), 8'h00);
`ifdef SD_SPI_IRQ_EN
        check("rst_irq", int'(bus.IRQ), 0);
`endif

        // Address 3 is inert
        bus_write(2'd3, 8'hFF);
        read_reg(2'd3, d); check("a3_read", int'(d), 8'h00);

        // DIV=0 loopback of 0xA5
        bus_write(2'd2, 8'h00);
        bus_write(2'd1, 8'h02);
        loop_en = 1'b1;
        bus_write(2'd0, 8'hA5);
        wait_byte(-1, 8'h00, bc, rises, seq);
        check("a5_busy_cycles", bc, 16);
        check("a5_sclk_pulses", rises, 8);
        check("a5_mosi_bits", int'(seq), 8'hA5);
        read_reg(2'd1, d); check("a5_status_done", int'(d), 8'h22);
        read_data_strobe(d); check("a5_rx", int'(d), 8'hA5);
        read_reg(2'd1, d); check("a5_done_cleared", int'(d), 8'h02);

        // DIV=3, MISO tied high, 0x00 out
        bus_write(2'd2, 8'h03);
        loop_en = 1'b0; miso_tie = 1'b1;
        bus_write(2'd0, 8'h00);
        wait_byte(-1, 8'h00, bc, rises, seq);
        check("ff_busy_cycles", bc, 64);
        check("ff_sclk_pulses", rises, 8);
        check("ff_mosi_bits", int'(seq), 8'h00);
        read_data_strobe(d); check("ff_rx", int'(d), 8'hFF);

        // Overrun: DATA write of 0x12 during 0x55
        loop_en = 1'b1;
        bus_write(2'd0, 8'h55);
        wait_byte(5, 8'h12, bc, rises, seq);
        check("ovr_busy_cycles", bc, 64);
        check("ovr_mosi_bits", int'(seq), 8'h55);
        read_reg(2'd1, d); check("ovr_status_set", int'(d), 8'h62);
        bus_write(2'd1, 8'h42);
        read_reg(2'd1, d); check("ovr_status_clr", int'(d), 8'h22);
        read_data_strobe(d); check("ovr_rx", int'(d), 8'h55);
        read_reg(2'd2, d); check("ovr_div_kept", int'(d), 8'h03);

        // DATA read held across the completing edge: DONE must survive
        bus_write(2'd2, 8'h00);
        bus_write(2'd0, 8'h3C);
        bus.CS = 1'b1; bus.RW = 1'b1; bus.A = 2'd0;
        repeat (16) @(negedge clk);
        #1 bus.CS = 1'b0;
        read_reg(2'd1, d); check("done_set_wins", int'(d), 8'h22);
        read_reg(2'd0, d); check("done_set_rx", int'(d), 8'h3C);

        // IEN / IRQ
        read_data_strobe(d);
        bus_write(2'd1, 8'h82);
        read_reg(2'd1, d); check("ien_status", int'(d), int'(IEN_BIT | 8'h02));
        bus_write(2'd0, 8'h81);
        wait_byte(-1, 8'h00, bc, rises, seq);
        check("irq_byte_bits", int'(seq), 8'h81);
`ifdef SD_SPI_IRQ_EN
        check("irq_high", int'(bus.IRQ), 1);
        read_data_strobe(d);
        #1 check("irq_low_after_read", int'(bus.IRQ), 0);
        bus_write(2'd1, 8'h02);
        bus_write(2'd0, 8'h18);
        wait_byte(-1, 8'h00, bc, rises, seq);
        check("irq_masked", int'(bus.IRQ), 0);
`endif

        // Reset in the high phase of bit 4
        bus_write(2'd2, 8'h03);
        bus_write(2'd1, 8'h00);
        bus_write(2'd0, 8'hC3);
        repeat (36) @(negedge clk);
        @(posedge clk);
        #2 res = 1'b1;
        #1;
        check("mid_rst_sclk", int'(bus.SCLK), 0);
        check("mid_rst_mosi", int'(bus.MOSI), 1);
        check("mid_rst_nsd0", int'(bus.nSD0), 1);
        check("mid_rst_nsd1", int'(bus.nSD1), 1);
        @(negedge clk);
        #1 res = 1'b0;
        repeat (80) @(negedge clk);
        #1;
        read_reg(2'd1, d); check("mid_rst_status", int'(d), 8'h03);
        read_reg(2'd2, d); check("mid_rst_div", int'(d), 8'h3B);
        read_reg(2'd0, d); check("mid_rst_rx", int'(d), 8'h00);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
